// File: rtl/sim_run_pkg.sv
// Shared definitions for the simulation / bring-up run controller:
// the run-state encoding and the default IO addresses of the halt
// register and the character output port.
package sim_run_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,   // core held in reset while the hold counter runs
        RUN     = 2'd1,   // core running, IO bus monitored
        HALTED  = 2'd2,   // run ended by a write to the halt address
        TIMEOUT = 2'd3    // run ended by the watchdog
    } run_state_e;

    localparam logic [31:0] DEF_HALT_ADDR = 32'h0003_0004;
    localparam logic [31:0] DEF_UART_ADDR = 32'h0003_0000;

endpackage : sim_run_pkg

// File: rtl/sim_char_fifo.sv
// Synchronous character FIFO fed by core UART writes.
// A push and a pop in the same cycle are both accepted, even when full.
// A push to a full FIFO without a pop drops the byte and sets a sticky
// overflow flag. The head byte reads as zero while the FIFO is empty.
module sim_char_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign do_pop  = pop_i && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push_i && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the array is deliberately not reset; the empty flag masks stale contents and the array can map to RAM.
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign valid_o    = !empty;
    assign data_o     = empty ? 8'h00 : mem[rd_ptr_q];
    assign overflow_o = overflow_q;

endmodule : sim_char_fifo

// File: rtl/sim_run_ctrl.sv
// Run controller for simulation and FPGA bring-up of the RISC-V core.
// Stretches the core reset for RST_CYCLES cycles, then lets the core run
// while watching its IO write bus for a halt write, and ends the run on a
// halt write or a watchdog expiry. All status outputs are registered.
// Optional character FIFO on UART writes: define SIM_RUN_CHAR_FIFO_EN.
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int                RST_CYCLES = 25,
    parameter int                MAX_CYCLES = 100,
    parameter int                CNT_W      = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(DEF_HALT_ADDR),
    parameter logic [ADDR_W-1:0] UART_ADDR  = ADDR_W'(DEF_UART_ADDR),
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [7:0]        io_data,
    output logic              core_rst,
    output logic              run_active,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [7:0]        exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              chr_valid,
    output logic [7:0]        chr_data,
    input  logic              chr_ready,
    output logic              chr_overflow
);

    localparam int               HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam bit               WD_EN     = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MAX_CYCLES - 1);

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        exit_code_q, exit_code_d;
    logic              core_rst_q, core_rst_d;
    logic              run_active_q, run_active_d;

    logic halt_wr;

    assign halt_wr = io_wr && (io_addr == HALT_ADDR);

    // Next-state and registered-output computation for the run FSM.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        exit_code_d = exit_code_q;

        case (state_q)
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
                // Halt takes priority over a watchdog expiry in the same cycle.
                if (halt_wr) begin
                    state_d     = HALTED;
                    done_d      = 1'b1;
                    pass_d      = 1'b1;
                    exit_code_d = io_data;
                end else if (WD_EN && (cycle_cnt_q == WD_LAST)) begin
                    state_d   = TIMEOUT;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                // HALTED and TIMEOUT are terminal; only rst_in leaves them.
                state_d = state_q;
            end
        endcase

        core_rst_d   = (state_d != RUN);
        run_active_d = (state_d == RUN);
    end

    // FSM state, counters and status registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            exit_code_q  <= 8'h00;
            core_rst_q   <= 1'b1;
            run_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            exit_code_q  <= exit_code_d;
            core_rst_q   <= core_rst_d;
            run_active_q <= run_active_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign run_active  = run_active_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign exit_code   = exit_code_q;
    assign cycle_count = cycle_cnt_q;

`ifdef SIM_RUN_CHAR_FIFO_EN
    logic chr_push;

    // Only UART writes made while the core runs enter the FIFO; it keeps draining afterwards.
    assign chr_push = (state_q == RUN) && io_wr && (io_addr == UART_ADDR);

    sim_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_char_fifo (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .push_i     (chr_push),
        .data_i     (io_data),
        .pop_i      (chr_ready),
        .valid_o    (chr_valid),
        .data_o     (chr_data),
        .overflow_o (chr_overflow)
    );
`else
    logic unused_chr_ok;

    // Character path absent: outputs tied off, consumer handshake ignored.
    assign chr_valid     = 1'b0;
    assign chr_data      = 8'h00;
    assign chr_overflow  = 1'b0;
    assign unused_chr_ok = &{1'b0, chr_ready, UART_ADDR, 32'(FIFO_DEPTH)};
`endif

endmodule : sim_run_ctrl

// File: tb/tb_sim_run_ctrl.sv
// Testbench for sim_run_ctrl: reset stretching, halt, watchdog, halt/watchdog
// collision, reset from a terminal state, disabled watchdog and the character
// path. Expected exit codes and characters go through scoreboard queues.
module tb_sim_run_ctrl;

    localparam logic [31:0] HALT = 32'h0003_0004;
    localparam logic [31:0] UART = 32'h0003_0000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        io_wr;
    logic [31:0] io_addr;
    logic [7:0]  io_data;
    logic        chr_ready;

    logic        core_rst, run_active, done, pass, timeout;
    logic [7:0]  exit_code;
    logic [31:0] cycle_count;
    logic        chr_valid, chr_overflow;
    logic [7:0]  chr_data;

    logic        n_core_rst, n_run_active, n_done, n_pass, n_timeout;
    logic [7:0]  n_exit_code;
    logic [31:0] n_cycle_count;
    logic        n_chr_valid, n_chr_overflow;
    logic [7:0]  n_chr_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_exit_q[$];
    logic [7:0] exp_chr_q[$];

    always #5 clk_in = ~clk_in;

    sim_run_ctrl dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .io_wr        (io_wr),
        .io_addr      (io_addr),
        .io_data      (io_data),
        .core_rst     (core_rst),
        .run_active   (run_active),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .exit_code    (exit_code),
        .cycle_count  (cycle_count),
        .chr_valid    (chr_valid),
        .chr_data     (chr_data),
        .chr_ready    (chr_ready),
        .chr_overflow (chr_overflow)
    );

    sim_run_ctrl #(
        .MAX_CYCLES (0)
    ) dut_nowd (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .io_wr        (io_wr),
        .io_addr      (io_addr),
        .io_data      (io_data),
        .core_rst     (n_core_rst),
        .run_active   (n_run_active),
        .done         (n_done),
        .pass         (n_pass),
        .timeout      (n_timeout),
        .exit_code    (n_exit_code),
        .cycle_count  (n_cycle_count),
        .chr_valid    (n_chr_valid),
        .chr_data     (n_chr_data),
        .chr_ready    (chr_ready),
        .chr_overflow (n_chr_overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic reset_dut();
        rst_in    = 1'b1;
        io_wr     = 1'b0;
        io_addr   = '0;
        io_data   = '0;
        chr_ready = 1'b0;
        repeat (3) tick();
        rst_in = 1'b0;
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [7:0] data);
        io_wr   = 1'b1;
        io_addr = addr;
        io_data = data;
        tick();
        io_wr   = 1'b0;
        io_addr = '0;
        io_data = '0;
    endtask

    // Counts cycles with core_rst still high, bounded.
    task automatic hold_len(output int n);
        n = 0;
        while (core_rst && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_core_rst"},   core_rst,     1);
        check({p, "_run_active"}, run_active,   0);
        check({p, "_done"},       done,         0);
        check({p, "_pass"},       pass,         0);
        check({p, "_timeout"},    timeout,      0);
        check({p, "_exit_code"},  exit_code,    0);
        check({p, "_cycle_cnt"},  cycle_count,  0);
        check({p, "_chr_valid"},  chr_valid,    0);
        check({p, "_chr_data"},   chr_data,     0);
        check({p, "_chr_ovf"},    chr_overflow, 0);
    endtask

    task automatic check_exit(input string tag);
        if (exp_exit_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            check(tag, exit_code, exp_exit_q.pop_front());
        end
    endtask

    // Compares the FIFO head with the scoreboard, then pops it for one cycle.
    task automatic pop_expect(input string tag);
        check({tag, "_valid"}, chr_valid, 1);
        if (exp_chr_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            check({tag, "_data"}, chr_data, exp_chr_q.pop_front());
        end
        chr_ready = 1'b1;
        tick();
        chr_ready = 1'b0;
    endtask

    initial begin
        int n;
        int k;

        // Reset timing; writes during HOLD must be ignored.
        reset_dut();
        check_reset("rst");
        io_write(HALT, 8'h11);
        io_write(UART, 8'h41);
        hold_len(n);
        check("hold_len", n + 2, 25);
        check("run_active_rise", run_active, 1);
        check("run_cnt0", cycle_count, 0);
        check("hold_halt_ignored", done, 0);
        check("hold_uart_ignored", chr_valid, 0);

`ifndef SIM_RUN_CHAR_FIFO_EN
        io_write(UART, 8'h48);
        check("nofifo_valid", chr_valid, 0);
        check("nofifo_data", chr_data, 0);
        check("nofifo_ovf", chr_overflow, 0);
`endif

        // Halt at cycle_count 40.
        k = 0;
        while (cycle_count != 40 && k < 100) begin
            tick();
            k++;
        end
        check("halt_at40", cycle_count, 40);
        exp_exit_q.push_back(8'h2A);
        io_write(HALT, 8'h2A);
        check("halt_done", done, 1);
        check("halt_pass", pass, 1);
        check("halt_timeout", timeout, 0);
        check_exit("halt_exit");
        check("halt_cnt", cycle_count, 41);
        check("halt_core_rst", core_rst, 1);
        check("halt_run_active", run_active, 0);
        io_write(HALT, 8'h55);
        repeat (5) tick();
        check("halt_exit_sticky", exit_code, 8'h2A);
        check("halt_cnt_frozen", cycle_count, 41);
        check("halt_still_pass", pass, 1);

        // Watchdog expiry.
        reset_dut();
        hold_len(n);
        check("wd_hold_len", n, 25);
        k = 0;
        while (!done && k < 300) begin
            tick();
            k++;
        end
        check("wd_run_len", k, 100);
        check("wd_timeout", timeout, 1);
        check("wd_pass", pass, 0);
        check("wd_cnt", cycle_count, 100);
        check("wd_exit", exit_code, 0);
        check("wd_core_rst", core_rst, 1);
        io_write(HALT, 8'h33);
        repeat (3) tick();
        check("wd_cnt_frozen", cycle_count, 100);
        check("wd_halt_ignored", pass, 0);
        check("nowd_no_timeout_early", n_timeout, 0);

        // Halt write in the watchdog expiry cycle.
        reset_dut();
        hold_len(n);
        repeat (99) tick();
        check("sim_cnt99", cycle_count, 99);
        check("sim_not_done", done, 0);
        exp_exit_q.push_back(8'h7E);
        io_write(HALT, 8'h7E);
        check("sim_pass", pass, 1);
        check("sim_timeout", timeout, 0);
        check("sim_done", done, 1);
        check_exit("sim_exit");

        // Reset pulse from HALTED.
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_reset("rst2");
        hold_len(n);
        check("rst2_hold_len", n, 25);

        // Watchdog disabled: no expiry after 10000 run cycles.
        repeat (10000) tick();
        check("nowd_timeout", n_timeout, 0);
        check("nowd_done", n_done, 0);
        check("nowd_run_active", n_run_active, 1);
        check("nowd_cnt", n_cycle_count, 10000);
        check("wd_on_timeout", timeout, 1);

`ifdef SIM_RUN_CHAR_FIFO_EN
        // Character FIFO.
        reset_dut();
        hold_len(n);
        check("fifo_empty0", chr_valid, 0);
        exp_chr_q.push_back(8'h48);
        io_write(UART, 8'h48);
        exp_chr_q.push_back(8'h69);
        io_write(UART, 8'h69);
        pop_expect("pop_H");
        pop_expect("pop_i");
        check("fifo_empty1", chr_valid, 0);
        for (int i = 0; i < 16; i++) begin
            exp_chr_q.push_back(8'h30 + 8'(i));
            io_write(UART, 8'h30 + 8'(i));
        end
        check("full_no_ovf", chr_overflow, 0);
        // Push and pop together on a full FIFO.
        check("pp_head", chr_data, exp_chr_q[0]);
        void'(exp_chr_q.pop_front());
        exp_chr_q.push_back(8'hA5);
        chr_ready = 1'b1;
        io_write(UART, 8'hA5);
        chr_ready = 1'b0;
        check("pp_no_ovf", chr_overflow, 0);
        // Push to a full FIFO with no pop: byte dropped.
        io_write(UART, 8'hEE);
        check("ovf_set", chr_overflow, 1);
        // End the run, then drain.
        exp_exit_q.push_back(8'h00);
        io_write(HALT, 8'h00);
        check("fifo_halt_pass", pass, 1);
        check_exit("fifo_halt_exit");
        k = 0;
        while (exp_chr_q.size() > 0 && k < 40) begin
            pop_expect("drain");
            k++;
        end
        check("drain_count", k, 16);
        check("drain_empty", chr_valid, 0);
        check("drain_ovf_sticky", chr_overflow, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sim_run_ctrl
